// File: rtl/operand_fetch.sv
// Operand fetch stage: 32-entry register file with write-back bypass, operand B
// selection and a single-entry ID/EX pipeline register with valid/ready handshake.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [15:0]       imm16,
    input  logic              use_imm,
    input  logic              sign_ext,
    input  logic [4:0]        shamt_in,
    input  logic [4:0]        alu_op_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic [5:0]        shamt,
    output logic [4:0]        ALUOp,
    output logic [REG_AW-1:0] dest_addr
);
    localparam int NUM_REGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;
    logic              rs_byp;
    logic              rt_byp;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] opb_next;
    logic              load;

    logic              valid_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic [5:0]        shamt_reg;
    logic [4:0]        alu_op_reg;
    logic [REG_AW-1:0] dest_reg;

    // Register 0 is never written (wr_en excludes it), so it stays at its reset value of 0.
    assign wr_en = wb_en && (wb_addr != '0);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs[gi] <= '0;
                end else if (wr_en && (wb_addr == REG_AW'(gi))) begin
                    regs[gi] <= wb_data;
                end
            end
        end
    endgenerate

    assign rs_byp = wr_en && (wb_addr == rs_addr);
    assign rt_byp = wr_en && (wb_addr == rt_addr);
    assign rs_val = rs_byp ? wb_data : regs[rs_addr];
    assign rt_val = rt_byp ? wb_data : regs[rt_addr];

    assign ext_imm  = sign_ext ? {{(DATA_W-16){imm16[15]}}, imm16}
                               : {{(DATA_W-16){1'b0}}, imm16};
    assign opb_next = use_imm ? ext_imm : rt_val;

    assign in_ready = !valid_reg || out_ready;
    assign load     = in_valid && in_ready;

    // Flush beats load: a load in the flush cycle belongs to the killed path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            shamt_reg  <= '0;
            alu_op_reg <= '0;
            dest_reg   <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg  <= 1'b1;
            opa_reg    <= rs_val;
            opb_reg    <= opb_next;
            shamt_reg  <= {1'b0, shamt_in};
            alu_op_reg <= alu_op_in;
            dest_reg   <= rd_addr;
        end else if (valid_reg && out_ready && !in_valid) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign opA       = opa_reg;
    assign opB       = opb_reg;
    assign shamt     = shamt_reg;
    assign ALUOp     = alu_op_reg;
    assign dest_addr = dest_reg;
endmodule
